register_file: RTL and testbench

- Small multi-ported register file for the processor datapath: 4 entries × 48 bits, two asynchronous read ports (A/B) and one synchronous write port.
- Feeds the two ALU operand buses (reg_a, reg_b).
- Writeback logic drives the write port.

---
 rtl/register_file.sv | 33 +++
 tb/tb_register_file.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W register file, two combinational read ports, one synchronous write port
module register_file #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_adr,
  input  logic [0:DATA_W-1] write_data,
  input  logic [ADDR_W-1:0] read_adr_a,
  input  logic [ADDR_W-1:0] read_adr_b,
  output logic [0:DATA_W-1] reg_a,
  output logic [0:DATA_W-1] reg_b
);
  localparam int N = 2**ADDR_W;
  logic [0:DATA_W-1] mem [N];
  logic fwd_ok;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (write_en) begin
      mem[write_adr] <= write_data;
    end
  end
  // forwarding is suppressed during reset so the ports read the cleared storage
  always_comb begin
    fwd_ok = (BYPASS != 0) && rst_n && write_en;
    reg_a = (fwd_ok && read_adr_a == write_adr) ? write_data : mem[read_adr_a];
    reg_b = (fwd_ok && read_adr_b == write_adr) ? write_data : mem[read_adr_b];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed checks of register_file with and without bypass
module tb_register_file;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        write_en = 0;
  logic [1:0]  write_adr = 0;
  logic [0:47] write_data = 0;
  logic [1:0]  read_adr_a = 0;
  logic [1:0]  read_adr_b = 0;
  logic [0:47] reg_a0, reg_b0, reg_a1, reg_b1;
  logic [0:47] model [4];
  int checks = 0;
  int errors = 0;

  register_file #(.DATA_W(48), .ADDR_W(2), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_adr(write_adr),
    .write_data(write_data), .read_adr_a(read_adr_a), .read_adr_b(read_adr_b),
    .reg_a(reg_a0), .reg_b(reg_b0));
  register_file #(.DATA_W(48), .ADDR_W(2), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_adr(write_adr),
    .write_data(write_data), .read_adr_a(read_adr_a), .read_adr_b(read_adr_b),
    .reg_a(reg_a1), .reg_b(reg_b1));

  always #5 clk = ~clk;

  task automatic write_cycle(input logic [1:0] a, input logic [0:47] d);
    @(negedge clk);
    write_en = 1; write_adr = a; write_data = d;
    @(posedge clk);
    model[a] = d;
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1;
    for (int a = 0; a < 4; a++) begin
      read_adr_a = 2'(a); read_adr_b = 2'(3 - a);
      #1;
      checks++;
      if (reg_a0 !== 48'h0 || reg_b0 !== 48'h0 || reg_a1 !== 48'h0 || reg_b1 !== 48'h0) begin
        errors++;
        $display("FAIL reset_init entry %0d: got a0=%h b0=%h a1=%h b1=%h expected 0", a, reg_a0, reg_b0, reg_a1, reg_b1);
      end
    end
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) write_cycle(2'(i), 48'(i + 1));
    @(negedge clk) write_en = 0;
  endtask

  task automatic test_readback;
    read_adr_a = 0; read_adr_b = 1;
    #1;
    checks++;
    if (reg_a0 !== 48'h1 || reg_b0 !== 48'h2 || reg_a1 !== 48'h1 || reg_b1 !== 48'h2) begin
      errors++;
      $display("FAIL readback_01: got a0=%h b0=%h a1=%h b1=%h expected 1 2", reg_a0, reg_b0, reg_a1, reg_b1);
    end
    read_adr_a = 2; read_adr_b = 3;
    #1;
    checks++;
    if (reg_a0 !== 48'h3 || reg_b0 !== 48'h4 || reg_a1 !== 48'h3 || reg_b1 !== 48'h4) begin
      errors++;
      $display("FAIL readback_23: got a0=%h b0=%h a1=%h b1=%h expected 3 4", reg_a0, reg_b0, reg_a1, reg_b1);
    end
  endtask

  task automatic test_write_disable;
    @(negedge clk);
    write_en = 0; write_adr = 1; write_data = 48'hFFFF_FFFF_FFFF;
    read_adr_a = 1; read_adr_b = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (reg_a0 !== 48'h2 || reg_b1 !== 48'h2 || reg_a1 !== 48'h2) begin
      errors++;
      $display("FAIL write_disable: got a0=%h a1=%h b1=%h expected 2", reg_a0, reg_a1, reg_b1);
    end
  endtask

  task automatic test_same_addr;
    read_adr_a = 2; read_adr_b = 2;
    #1;
    checks++;
    if (reg_a0 !== 48'h3 || reg_b0 !== 48'h3 || reg_a1 !== 48'h3 || reg_b1 !== 48'h3) begin
      errors++;
      $display("FAIL same_addr: got a0=%h b0=%h a1=%h b1=%h expected 3", reg_a0, reg_b0, reg_a1, reg_b1);
    end
  endtask

  task automatic test_rdw;
    @(negedge clk);
    write_en = 1; write_adr = 0; write_data = 48'hABCD_0000_1234;
    read_adr_a = 0; read_adr_b = 1;
    #1;
    checks++;
    if (reg_a0 !== 48'h1) begin
      errors++;
      $display("FAIL rdw_pre_nobypass: got %h expected %h", reg_a0, 48'h1);
    end
    checks++;
    if (reg_a1 !== 48'hABCD_0000_1234 || reg_b1 !== 48'h2) begin
      errors++;
      $display("FAIL rdw_pre_bypass: got a=%h b=%h expected abcd00001234 2", reg_a1, reg_b1);
    end
    @(posedge clk);
    model[0] = 48'hABCD_0000_1234;
    #1;
    checks++;
    if (reg_a0 !== 48'hABCD_0000_1234 || reg_a1 !== 48'hABCD_0000_1234) begin
      errors++;
      $display("FAIL rdw_post: got a0=%h a1=%h expected abcd00001234", reg_a0, reg_a1);
    end
    @(negedge clk) write_en = 0;
  endtask

  task automatic test_msb;
    write_cycle(3, 48'h8000_0000_0000);
    @(negedge clk) write_en = 0;
    read_adr_b = 3;
    #1;
    checks++;
    if (reg_b0[0] !== 1'b1 || reg_b0[1:47] !== 47'h0 || reg_b1 !== 48'h8000_0000_0000) begin
      errors++;
      $display("FAIL msb_order: got b0=%h b1=%h expected 800000000000", reg_b0, reg_b1);
    end
    for (int i = 0; i < 3; i++) begin
      read_adr_a = 2'(i);
      #1;
      checks++;
      if (reg_a0 !== model[i] || reg_a1 !== model[i]) begin
        errors++;
        $display("FAIL msb_others entry %0d: got a0=%h a1=%h expected %h", i, reg_a0, reg_a1, model[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [0:47] ea0, eb0, ea1, eb1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      write_en = 1'($urandom_range(0, 1));
      write_adr = 2'($urandom_range(0, 3));
      write_data = {16'($urandom()), 32'($urandom())};
      read_adr_a = 2'($urandom_range(0, 3));
      read_adr_b = 2'($urandom_range(0, 3));
      ea0 = model[read_adr_a];
      eb0 = model[read_adr_b];
      ea1 = (write_en && read_adr_a == write_adr) ? write_data : ea0;
      eb1 = (write_en && read_adr_b == write_adr) ? write_data : eb0;
      #1;
      checks++;
      if (reg_a0 !== ea0 || reg_b0 !== eb0 || reg_a1 !== ea1 || reg_b1 !== eb1) begin
        errors++;
        $display("FAIL random_read %0d: got a0=%h b0=%h a1=%h b1=%h expected %h %h %h %h",
                 n, reg_a0, reg_b0, reg_a1, reg_b1, ea0, eb0, ea1, eb1);
      end
      @(posedge clk);
      if (write_en) model[write_adr] = write_data;
    end
    @(negedge clk) write_en = 0;
    for (int i = 0; i < 4; i++) begin
      read_adr_a = 2'(i); read_adr_b = 2'(i);
      #1;
      checks++;
      if (reg_a0 !== model[i] || reg_b1 !== model[i]) begin
        errors++;
        $display("FAIL random_final entry %0d: got a0=%h b1=%h expected %h", i, reg_a0, reg_b1, model[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    write_cycle(1, 48'h1234_5678_9ABC);
    @(negedge clk) write_en = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    for (int a = 0; a < 4; a++) begin
      read_adr_a = 2'(a); read_adr_b = 2'(3 - a);
      #1;
      checks++;
      if (reg_a0 !== 48'h0 || reg_b0 !== 48'h0 || reg_a1 !== 48'h0 || reg_b1 !== 48'h0) begin
        errors++;
        $display("FAIL async_reset entry %0d: got a0=%h b0=%h a1=%h b1=%h expected 0", a, reg_a0, reg_b0, reg_a1, reg_b1);
      end
    end
    for (int i = 0; i < 4; i++) model[i] = '0;
    write_en = 1; write_adr = 0; write_data = 48'hFFFF_FFFF_FFFF; read_adr_a = 0;
    #1;
    checks++;
    if (reg_a1 !== 48'h0 || reg_a0 !== 48'h0) begin
      errors++;
      $display("FAIL reset_no_bypass: got a0=%h a1=%h expected 0", reg_a0, reg_a1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (reg_a0 !== 48'h0 || reg_a1 !== 48'h0) begin
      errors++;
      $display("FAIL reset_write_ignored: got a0=%h a1=%h expected 0", reg_a0, reg_a1);
    end
    @(negedge clk);
    write_en = 0; rst_n = 1;
    #1;
    checks++;
    if (reg_a0 !== model[0] || reg_a1 !== model[0]) begin
      errors++;
      $display("FAIL post_reset: got a0=%h a1=%h expected %h", reg_a0, reg_a1, model[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model[i] = '0;
    test_reset;
    test_fill;
    test_readback;
    test_write_disable;
    test_same_addr;
    test_rdw;
    test_msb;
    test_random;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
